// File: rtl/hazard_stall_unit.sv
// Hazard/stall control at the ID/EX boundary: load-use stalls, iterative MUL hold,
// flush priority and a saturating stall-cycle counter for performance debug.
module hazard_stall_unit #(
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             mem_read_ID_EX,
  input  logic [4:0]       RegisterRD_ID_EX,
  input  logic [4:0]       RS1_IF_ID,
  input  logic [4:0]       RS2_IF_ID,
  input  logic             use_rs1_IF_ID,
  input  logic             use_rs2_IF_ID,
  input  logic             mul_ID_EX,
  input  logic             flush,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             id_ex_write_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             mul_busy,
  output logic             mul_done,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned CW = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CW-1:0]    CNT_START = CW'(MUL_LATENCY - 2);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [CNT_W-1:0] STALL_MAX = '1;
  localparam logic [CNT_W-1:0] STALL_ONE = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          hold;
  logic          done;
  logic          rs1_hit;
  logic          rs2_hit;
  logic          load_use;

  // Multiplier sequencing: entry cycle plus MUL_LATENCY-2 further hold cycles, then done.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hold      = 1'b0;
    done      = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (mul_ID_EX) begin
            hold      = 1'b1;
            state_nxt = BUSY;
            cnt_nxt   = CNT_START;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            hold    = 1'b1;
            cnt_nxt = cnt - CNT_ONE;
          end else begin
            done      = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign rs1_hit  = (RegisterRD_ID_EX == RS1_IF_ID) && use_rs1_IF_ID;
  assign rs2_hit  = (RegisterRD_ID_EX == RS2_IF_ID) && use_rs2_IF_ID;
  assign load_use = mem_read_ID_EX && (RegisterRD_ID_EX != 5'd0) && (rs1_hit || rs2_hit);

  // Pipeline controls, priority: reset, flush, MUL hold, load-use.
  always_comb begin
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    id_ex_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    ex_mem_bubble  = 1'b0;
    mul_done       = 1'b0;
    if (!arst) begin
      mul_done = done;
      if (flush) begin
        if_id_flush   = 1'b1;
        id_ex_bubble  = 1'b1;
        ex_mem_bubble = 1'b1;
      end else if (hold) begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        id_ex_write_en = 1'b0;
        ex_mem_bubble  = 1'b1;
      end else if (load_use) begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        id_ex_bubble   = 1'b1;
      end
    end
  end

  assign mul_busy = (state == BUSY);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stall_cycles <= '0;
    end else if (!pc_write_en && (stall_cycles != STALL_MAX)) begin
      stall_cycles <= stall_cycles + STALL_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: driver pushes model expectations, monitor compares each cycle.
module tb_hazard_stall_unit;

  localparam int unsigned L     = 4;
  localparam int unsigned CW    = 4;
  localparam int          SAT   = (1 << CW) - 1;

  typedef struct packed {
    logic          pc;
    logic          ifid;
    logic          idex;
    logic          ifid_flush;
    logic          idex_bubble;
    logic          exmem_bubble;
    logic          busy;
    logic          done;
    logic [CW-1:0] stall;
  } exp_t;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic          mem_read = 1'b0;
  logic [4:0]    rd = '0;
  logic [4:0]    rs1 = '0;
  logic [4:0]    rs2 = '0;
  logic          use1 = 1'b0;
  logic          use2 = 1'b0;
  logic          mul = 1'b0;
  logic          flush = 1'b0;
  logic          pc_write_en, if_id_write_en, id_ex_write_en;
  logic          if_id_flush, id_ex_bubble, ex_mem_bubble, mul_busy, mul_done;
  logic [CW-1:0] stall_cycles;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: MUL occupancy by age, and total stalled cycles since reset.
  bit   mul_active = 0;
  int   mul_age = 0;
  int   stalled = 0;

  hazard_stall_unit #(.MUL_LATENCY(L), .CNT_W(CW)) dut (
    .clk(clk), .arst(arst),
    .mem_read_ID_EX(mem_read), .RegisterRD_ID_EX(rd),
    .RS1_IF_ID(rs1), .RS2_IF_ID(rs2),
    .use_rs1_IF_ID(use1), .use_rs2_IF_ID(use2),
    .mul_ID_EX(mul), .flush(flush),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en), .id_ex_write_en(id_ex_write_en),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
    .mul_busy(mul_busy), .mul_done(mul_done), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic step(input logic a, input logic mr, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic u1, input logic u2,
                      input logic ml, input logic fl);
    exp_t e;
    bit   hold;
    bit   done;
    @(posedge clk);
    #1;
    arst = a; mem_read = mr; rd = d; rs1 = s1; rs2 = s2;
    use1 = u1; use2 = u2; mul = ml; flush = fl;
    e = '0;
    e.pc = 1'b1; e.ifid = 1'b1; e.idex = 1'b1;
    hold = 0;
    done = 0;
    if (a) begin
      mul_active = 0;
      mul_age = 0;
      stalled = 0;
    end else begin
      e.busy  = mul_active;
      e.stall = CW'((stalled > SAT) ? SAT : stalled);
      if (fl) begin
        e.ifid_flush = 1'b1; e.idex_bubble = 1'b1; e.exmem_bubble = 1'b1;
        mul_active = 0;
        mul_age = 0;
      end else begin
        if (mul_active) begin
          if (mul_age < L - 1) begin
            hold = 1;
            mul_age++;
          end else begin
            done = 1;
            mul_active = 0;
          end
        end else if (ml) begin
          hold = 1;
          mul_active = 1;
          mul_age = 1;
        end
        if (hold) begin
          e.pc = 1'b0; e.ifid = 1'b0; e.idex = 1'b0; e.exmem_bubble = 1'b1;
        end else if (mr && d != 0 && ((d == s1 && u1) || (d == s2 && u2))) begin
          e.pc = 1'b0; e.ifid = 1'b0; e.idex_bubble = 1'b1;
        end
      end
      e.done = done;
      if (!e.pc) stalled++;
    end
    q.push_back(e);
  endtask

  task automatic idle_cycle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitor: outputs are combinational, so sample mid-cycle on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc_write_en",    int'(pc_write_en),    int'(e.pc));
        chk("if_id_write_en", int'(if_id_write_en), int'(e.ifid));
        chk("id_ex_write_en", int'(id_ex_write_en), int'(e.idex));
        chk("if_id_flush",    int'(if_id_flush),    int'(e.ifid_flush));
        chk("id_ex_bubble",   int'(id_ex_bubble),   int'(e.idex_bubble));
        chk("ex_mem_bubble",  int'(ex_mem_bubble),  int'(e.exmem_bubble));
        chk("mul_busy",       int'(mul_busy),       int'(e.busy));
        chk("mul_done",       int'(mul_done),       int'(e.done));
        chk("stall_cycles",   int'(stall_cycles),   int'(e.stall));
      end
    end
  end

  initial begin
    step(1, 1, 5, 5, 5, 1, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 1);
    idle_cycle();
    // Load-use on rs1, then x0 and unused-operand cases that must not stall.
    step(0, 1, 5, 5, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 1, 0, 0);
    step(0, 1, 5, 0, 5, 0, 0, 0, 0);
    step(0, 1, 7, 1, 7, 0, 1, 0, 0);
    idle_cycle();
    // Single MUL then back-to-back MULs with no gap.
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle_cycle();
    // Flush on the third cycle of a MUL, with mul asserted alongside flush.
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    repeat (2) idle_cycle();
    step(0, 1, 3, 3, 3, 1, 1, 1, 1);
    idle_cycle();
    // Async reset arriving mid-MUL, held for two cycles.
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 1, 5, 5, 0, 1, 0, 0, 0);
    idle_cycle();
    // Counter saturation with 20 consecutive load-use stalls.
    repeat (20) step(0, 1, 9, 9, 2, 1, 0, 0, 0);
    repeat (2) idle_cycle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Randomized traffic over a small register set to provoke matches.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(99) < 2), ($urandom_range(99) < 40),
           5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
           1'($urandom), 1'($urandom), ($urandom_range(99) < 15), ($urandom_range(99) < 7));
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
